// File: rtl/weakbus_pkg.sv
// weakbus_pkg: address map, controller states and target-select encoding for weakbus
package weakbus_pkg;
  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] TXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;
  localparam logic [31:0] CYCLE_OFF = 32'h8;
  typedef enum logic {IDLE, ACK} state_t;
  typedef enum logic [2:0] {T_RAM, T_TXDATA, T_STATUS, T_CYCLE, T_NONE} target_t;
  function automatic logic mmio_hit(input logic [31:0] addr, input logic [31:0] off);
    logic [31:0] t;
    t = MMIO_BASE + off;
    return addr[31:2] == t[31:2];
  endfunction
endpackage

// File: rtl/weakbus_if.sv
// weakbus_if: core memory-port handshake between the RV32I core and weakbus
interface weakbus_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_req;
  logic bus_ack;
  logic bus_wr;
  logic [3:0] bus_wr_mask;
  modport master(output bus_addr, bus_wdata, bus_req, bus_wr, bus_wr_mask, input bus_rdata, bus_ack);
  modport slave(input bus_addr, bus_wdata, bus_req, bus_wr, bus_wr_mask, output bus_rdata, bus_ack);
endinterface

// File: rtl/weakbus_uart_tx.sv
// weakbus_uart_tx: 4-entry byte FIFO feeding an 8N1 serial shifter
module weakbus_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic active, pop;
  logic [3:0] bit_idx;
  logic [CW-1:0] clk_cnt;
  logic [9:0] frame;
  assign pop = !active && count != 3'd0;
  assign full = count == 3'd4;
  assign busy = active || count != 3'd0;
  assign tx = active ? frame[0] : 1'b1;
  always_ff @(posedge clk)
    if (push) fifo[wp] <= push_data;
  // frame holds {stop, data, start}; shifting right puts each bit on frame[0] in turn
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      active <= 1'b0;
      bit_idx <= '0;
      clk_cnt <= '0;
      frame <= '1;
    end else begin
      wp <= wp + 2'(push);
      rp <= rp + 2'(pop);
      count <= count + 3'(push) - 3'(pop);
      if (pop) begin
        active <= 1'b1;
        bit_idx <= '0;
        clk_cnt <= '0;
        frame <= {1'b1, fifo[rp], 1'b0};
      end else if (active) begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt <= '0;
          frame <= {1'b1, frame[9:1]};
          bit_idx <= bit_idx + 4'd1;
          active <= bit_idx != 4'd9;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/weakbus.sv
// weakbus: word-aligned bus slave serving RAM, UART/STATUS/CYCLE MMIO and a silent default region
module weakbus
  import weakbus_pkg::*;
#(
  parameter int    RAM_WORDS    = 4096,
  parameter string RAM_INIT     = "",
  parameter int    CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  weakbus_if.slave  bus,
  output logic      uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_q, snap, cycle;
  state_t state, next;
  target_t tgt, sel;
  logic accept, push, full, busy, unused_ok;
  logic [AW-1:0] idx;
  assign idx = bus.bus_addr[AW+1:2];
  assign unused_ok = &{1'b0, bus.bus_addr[1:0]};
  always_comb
    tgt = bus.bus_addr[31:AW+2] == '0 ? T_RAM :
          mmio_hit(bus.bus_addr, TXDATA_OFF) ? T_TXDATA :
          mmio_hit(bus.bus_addr, STATUS_OFF) ? T_STATUS :
          mmio_hit(bus.bus_addr, CYCLE_OFF) ? T_CYCLE : T_NONE;
  // a TXDATA write against a full FIFO is held off, which is what keeps the FIFO from overflowing
  always_comb begin
    accept = state == IDLE && bus.bus_req && !(tgt == T_TXDATA && bus.bus_wr && full);
    next = state == IDLE && accept ? ACK : IDLE;
  end
  assign push = accept && tgt == T_TXDATA && bus.bus_wr && bus.bus_wr_mask[0];
  always_ff @(posedge clk)
    state <= !rst ? IDLE : next;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle <= '0;
      sel <= T_NONE;
      snap <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (accept) begin
        sel <= tgt;
        snap <= tgt == T_CYCLE ? cycle : tgt == T_STATUS ? {30'b0, busy, full} : '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (accept && tgt == T_RAM) begin
      ram_q <= ram[idx];
      if (bus.bus_wr)
        for (int i = 0; i < 4; i++)
          if (bus.bus_wr_mask[i]) ram[idx][8*i +: 8] <= bus.bus_wdata[8*i +: 8];
    end
  assign bus.bus_ack = state == ACK;
  assign bus.bus_rdata = state != ACK ? '0 : sel == T_RAM ? ram_q : snap;
  weakbus_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(bus.bus_wdata[7:0]),
    .full(full),
    .busy(busy),
    .tx(uart_tx)
  );
endmodule
